// File: rtl/seg7_scan_display.sv
// Multi-digit common-anode 7-segment driver: signed input -> iterative BCD -> multiplexed scan.
// Define LEADING_ZERO_BLANK_EN for leading-zero blanking with a floating minus sign.
module seg7_scan_display #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic              value_valid,
  output logic              value_ready,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SEL_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic                     neg_q, neg_d;
  logic                     ovf_q, ovf_d;
  logic [DATA_W-1:0]        mag_q, mag_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [BCD_W-1:0]         adj;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DIGITS-1:0][6:0]   disp_q, disp_d, build;
  logic                     ovf_fin;

  logic [REF_W-1:0]         ref_q, ref_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic [DIGITS-1:0]        an_q, an_d;

`ifdef LEADING_ZERO_BLANK_EN
  int msd;
`endif

  // Scan: the display register is the only source, so a LOAD never tears a digit.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    sel_d = sel_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
    end
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (sel_q != SEL_W'(i));
    end
    seg_d = disp_q[sel_q];
    dp_d  = ~dp_mask[sel_q];
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A negative value needs the top digit free for its sign.
  assign ovf_fin = ovf_q | (neg_q & (|bcd_q[BCD_W-1 -: 4]));

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (|bcd_q[4*i +: 4]) msd = i;
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      build[i] = (i > msd) ? SEG_BLANK : seg_code(bcd_q[4*i +: 4]);
      if (neg_q && (i == msd + 1)) build[i] = SEG_DASH;
`else
      build[i] = seg_code(bcd_q[4*i +: 4]);
      if (neg_q && (i == DIGITS - 1)) build[i] = SEG_DASH;
`endif
      if (ovf_fin) build[i] = SEG_DASH;
    end
  end

  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    value_ready = 1'b0;
    case (state_q)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) begin
          neg_d   = value[DATA_W-1];
          mag_d   = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj[BCD_W-2:0], mag_q[DATA_W-1]};
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
        ovf_d = ovf_q | adj[BCD_W-1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = LOAD;
      end
      LOAD: begin
        ovf_d   = ovf_fin;
        disp_d  = build;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= {DIGITS{SEG_BLANK}};
      ref_q   <= '0;
      sel_q   <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a 4-digit and a 2-digit instance against a decimal-arithmetic model.
module tb_seg7_scan_display;

  localparam int DW = 8;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef logic [7:0][6:0] disp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = '0;
  logic       value_valid = 1'b0;
  logic [3:0] dp_mask = '0;

  logic       rdy_a, dp_a, rdy_b, dp_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a;
  logic [1:0] an_b;

  always #5 clk = ~clk;

  seg7_scan_display #(.DIGITS(4), .DATA_W(DW), .REFRESH_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(rdy_a), .dp_mask(dp_mask), .seg(seg_a), .dp(dp_a), .an(an_a));

  seg7_scan_display #(.DIGITS(2), .DATA_W(DW), .REFRESH_DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(rdy_b), .dp_mask(dp_mask[1:0]), .seg(seg_b), .dp(dp_b), .an(an_b));

  int vectors = 0;
  int miscompares = 0;

  int    nd[2] = '{4, 2};
  int    rd[2] = '{4, 3};
  int    n[2];
  int    busy[2];
  disp_t disp[2];
  disp_t pend[2];
  logic [31:0] ex_an[2], ex_seg[2], ex_dp[2];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // What an ndig-digit display must show for signed integer v.
  function automatic disp_t model_disp(input int v, input int ndig);
    disp_t r;
    int mag, lim, sig, div;
    bit neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    lim = 1;
    for (int i = 0; i < (neg ? ndig - 1 : ndig); i++) lim *= 10;
    for (int i = 0; i < 8; i++) r[i] = BLANK;
    if (mag >= lim) begin
      for (int i = 0; i < ndig; i++) r[i] = DASH;
      return r;
    end
`ifdef LEADING_ZERO_BLANK_EN
    sig = 1;
    div = 10;
    while (mag >= div) begin
      sig++;
      div *= 10;
    end
`else
    sig = ndig;
`endif
    div = 1;
    for (int i = 0; i < sig; i++) begin
      r[i] = seg_of((mag / div) % 10);
      div *= 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (neg) r[sig] = DASH;
`else
    if (neg) r[ndig-1] = DASH;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    int sel;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        n[u] = 0;
        busy[u] = 0;
        for (int i = 0; i < 8; i++) disp[u][i] = BLANK;
        ex_an[u]  = (1 << nd[u]) - 1;
        ex_seg[u] = 32'(BLANK);
        ex_dp[u]  = 1;
      end else begin
        sel = (n[u] / rd[u]) % nd[u];
        ex_an[u]  = ((1 << nd[u]) - 1) & ~(1 << sel);
        ex_seg[u] = 32'(disp[u][sel]);
        ex_dp[u]  = 32'(!dp_mask[sel]);
        n[u]++;
        if (busy[u] > 0) begin
          busy[u]--;
          if (busy[u] == 0) disp[u] = pend[u];
        end else if (value_valid) begin
          pend[u] = model_disp($signed(value), nd[u]);
          busy[u] = DW + 1;
        end
      end
    end
    @(negedge clk);
    chk("an_a",  {28'b0, an_a},  ex_an[0]);
    chk("seg_a", {25'b0, seg_a}, ex_seg[0]);
    chk("dp_a",  {31'b0, dp_a},  ex_dp[0]);
    chk("rdy_a", {31'b0, rdy_a}, 32'(busy[0] == 0));
    chk("an_b",  {30'b0, an_b},  ex_an[1]);
    chk("seg_b", {25'b0, seg_b}, ex_seg[1]);
    chk("dp_b",  {31'b0, dp_b},  ex_dp[1]);
    chk("rdy_b", {31'b0, rdy_b}, 32'(busy[1] == 0));
  endtask

  task automatic send(input int v, input int wait_cycles);
    value = 8'(v);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    repeat (wait_cycles) step();
  endtask

  initial begin
    disp_t t;
    logic [3:0] an_log [20];
    logic [3:0] an_exp [5];
    int cnt;

    an_exp = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    t = model_disp(25, 4);
    chk("pin25_d0", 32'(t[0]), 32'(7'b0010010));
    chk("pin25_d1", 32'(t[1]), 32'(7'b0100100));
    t = model_disp(-128, 4);
    chk("pinm128_d3", 32'(t[3]), 32'(DASH));
    chk("pinm128_d2", 32'(t[2]), 32'(7'b1111001));
    chk("pinm128_d0", 32'(t[0]), 32'(7'b0000000));
    t = model_disp(-7, 4);
    chk("pinm7_d0", 32'(t[0]), 32'(7'b1111000));
    t = model_disp(100, 2);
    chk("pin100_d1", 32'(t[1]), 32'(DASH));
    t = model_disp(-9, 2);
    chk("pinm9_d1", 32'(t[1]), 32'(DASH));
    chk("pinm9_d0", 32'(t[0]), 32'(7'b0010000));

    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      an_log[k] = an_a;
    end
    for (int k = 0; k < 5; k++) chk("an_seq", 32'(an_log[4*k]), 32'(an_exp[k]));

    send(25, 0);
    cnt = 0;
    for (int k = 0; k < 20 && !rdy_a; k++) begin
      step();
      cnt++;
    end
    chk("rdy_low_cycles", 32'(cnt), 32'd9);
    repeat (20) begin
      step();
      if (an_a == 4'hE) chk("seg25_d0", 32'(seg_a), 32'(7'b0010010));
    end

    send(-7, 20);
    send(-128, 20);
    dp_mask = 4'b0010;
    send(0, 20);
    dp_mask = 4'b0000;
    send(100, 12);
    send(-10, 12);
    send(-9, 20);

    send(42, 0);
    value = 8'd99;
    value_valid = 1'b1;
    repeat (4) step();
    value_valid = 1'b0;
    repeat (30) step();

    send(77, 3);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();

    for (int k = 0; k < 600; k++) begin
      value = 8'($urandom);
      dp_mask = 4'($urandom);
      value_valid = ($urandom_range(0, 7) == 0);
      step();
    end
    value_valid = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multi-digit 7-segment display driver. Successor to the fixed 3-digit temperature display.
- Accepts a signed two's-complement value through a valid/ready handshake and converts it to BCD with an iterative shift-add-3 engine, so no combinational divide is used.
- Shows the result on a time-multiplexed common-anode display with leading-zero blanking, a minus sign, an overflow indication and per-digit decimal points.
- Sits between the XADC temperature path and the board display pins.

Parameters:
- DIGITS, 4: number of physical digits, range 2..8.
- DATA_W, 8: width of the signed input value, range 4..24.
- REFRESH_DIV, 100000: clk cycles each digit stays enabled (1 kHz per digit at 100 MHz). Minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- value  in  DATA_W  signed two's-complement value to display.
- value_valid  in  1  value is presented.
- value_ready  out  1  converter idle; transfer occurs when value_valid && value_ready at a rising clk edge.
- dp_mask  in  DIGITS  decimal point request per digit (bit 0 = rightmost digit), active high, sampled live.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- an  out  DIGITS  digit enables, active low, one-hot-low.

Behaviour:
- Reset (async assert, sync release) values:
  - seg=7'h7F, dp=1, an=all ones, value_ready=1.
  - Display register = all blank, overflow flag=0.
  - Refresh counter=0, digit_sel=0, converter state IDLE.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and digit_sel advances 0..DIGITS-1, wrapping to 0.
  - seg, dp and an are registered: an[digit_sel]=0 with all other bits 1.
  - First enable after reset is an[0]=0, asserted on the first clk edge after reset release.
- Converter FSM, states IDLE -> CONV -> LOAD -> IDLE:
  - IDLE: value_ready=1. On transfer, capture neg=value[DATA_W-1] and mag=|value| as a DATA_W-bit unsigned (the most negative input is representable). Clear the BCD register (4*DIGITS bits) and the ovf flag. Go to CONV.
  - CONV: value_ready=0. Exactly DATA_W cycles. Each cycle, add 3 to every BCD digit >=5, then shift {bcd,mag} left by 1. Any 1 shifted out of the BCD MSB sets ovf (sticky).
  - LOAD: one cycle. If neg and BCD digit DIGITS-1 is nonzero, set ovf (no room for the sign). Build the display register atomically, then return to IDLE.
  - Latency: value_ready is low for DATA_W+1 cycles after the accept edge. The new value is visible on seg at the next scan update after LOAD.
- Display register build:
  - If ovf: every digit shows '-' (7'b0111111).
  - Otherwise: digits above the most significant nonzero BCD digit are blank (7'h7F). A value of 0 shows '0' on digit 0 only.
  - If neg: '-' goes in the digit immediately left of the most significant nonzero digit.
  - The display never tears: the scan only reads the display register, which changes only in LOAD.
- Segment codes, active low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dp = ~dp_mask[digit_sel], independent of the display contents.
- value_valid while value_ready=0: ignored, nothing queued. The source must hold the value until the transfer occurs.
- Reset mid-conversion: the conversion is aborted and all state returns to reset values. The display is blank until the next completed conversion.
- -0 does not exist. An input equal to the most negative value converts as its full magnitude.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading-zero blanking and floating minus sign exactly as in Behaviour.
- Undefined:
  - All DIGITS digits show numerals, including leading zeros.
  - For negative values, digit DIGITS-1 shows '-' and the magnitude must fit in DIGITS-1 digits, otherwise ovf.
  - Positive values use all digits.

Test Plan:
- Reset: hold rst_n=0 -> seg=7'h7F, an=4'hF, dp=1, value_ready=1. With REFRESH_DIV=4 after release: an steps E,D,B,7,E, one step every 4 cycles.
- Latency/handshake: value=25 with valid for 1 cycle -> value_ready low for exactly 9 cycles. Then an=E gives seg=0010010, an=D gives 0100100, an=B and an=7 give 7F.
- Negative: value=8'hF9 (-7) -> digit0 1111000, digit1 0111111 ('-'), digits 2-3 blank. Value=8'h80 (-128) -> '-','1','2','8'.
- Zero and decimal point: value=0, dp_mask=4'b0010 -> digit0 1000000, others 7F; dp=0 only while an=D.
- Overflow, DIGITS=2: value=100 -> both digits 0111111. Value=-10 -> both 0111111. Value=-9 -> '-','9'.
- Busy and reset abort: send 42, then assert valid with 99 during CONV -> display shows 42 and 99 is ignored. Pulse rst_n low mid-conversion -> all digits blank, value_ready=1.
